// File: rtl/gpu_scanout.sv
`default_nettype none
// ============================================================================
// gpu_scanout : VGA-style scanout of a ROM image and a RAM image side by side.
// Optional build macro: SCANOUT_BORDER_EN (white 1-px frames around both).
// Rev 1.0
// ============================================================================
module gpu_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_SIZE = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  GPUData,
  input  logic [7:0]  GPUDataRom,
  output logic [15:0] GPUAddress,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        frameStart
);

  localparam int CW     = 12;
  // Equal outer margins, gap between the images is twice the margin.
  localparam int MARGIN = (H_ACTIVE - 2*IMG_SIZE) / 4;
  localparam int WIN_Y  = (V_ACTIVE - IMG_SIZE) / 2;

  localparam logic [CW-1:0] C_H_LAST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] C_V_LAST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] C_H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] C_V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] C_HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] C_HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] C_VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] C_VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] C_ROM_X0 = CW'(MARGIN);
  localparam logic [CW-1:0] C_ROM_X1 = CW'(MARGIN + IMG_SIZE);
  localparam logic [CW-1:0] C_RAM_X0 = CW'(3*MARGIN + IMG_SIZE);
  localparam logic [CW-1:0] C_RAM_X1 = CW'(3*MARGIN + 2*IMG_SIZE);
  localparam logic [CW-1:0] C_WIN_Y0 = CW'(WIN_Y);
  localparam logic [CW-1:0] C_WIN_Y1 = CW'(WIN_Y + IMG_SIZE);
  localparam logic [15:0]   C_IMG    = 16'(IMG_SIZE);

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_ROM   = 2'd1,
    CLS_RAM   = 2'd2,
    CLS_WHITE = 2'd3
  } cls_e;

  logic          phase_q, phase_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [15:0]   addr_q, addr_d;
  cls_e          cls1_q, cls1_d;
  logic          blank1_q, blank1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [7:0]    pix_q, pix_d;
  logic          blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
  logic          frame_q, frame_d;

  logic          w_in_y, w_rom, w_ram, w_vis, w_border;
  logic [CW-1:0] w_lx, w_ly;
  logic [15:0]   w_addr;
  cls_e          w_cls;

  always_comb begin
    w_in_y = (v_q >= C_WIN_Y0) && (v_q < C_WIN_Y1);
    w_rom  = w_in_y && (h_q >= C_ROM_X0) && (h_q < C_ROM_X1);
    w_ram  = w_in_y && (h_q >= C_RAM_X0) && (h_q < C_RAM_X1);
    w_vis  = (h_q < C_H_ACT) && (v_q < C_V_ACT);
    w_lx   = w_rom ? (h_q - C_ROM_X0) : (h_q - C_RAM_X0);
    w_ly   = v_q - C_WIN_Y0;
    w_addr = (w_rom || w_ram) ? (16'(w_ly) * C_IMG + 16'(w_lx)) : 16'd0;
  end

`ifdef SCANOUT_BORDER_EN
  localparam logic [CW-1:0] C_BY0 = CW'(WIN_Y - 1);
  localparam logic [CW-1:0] C_BY1 = CW'(WIN_Y + IMG_SIZE);
  localparam logic [CW-1:0] C_BR0 = CW'(MARGIN - 1);
  localparam logic [CW-1:0] C_BR1 = CW'(MARGIN + IMG_SIZE);
  localparam logic [CW-1:0] C_BM0 = CW'(3*MARGIN + IMG_SIZE - 1);
  localparam logic [CW-1:0] C_BM1 = CW'(3*MARGIN + 2*IMG_SIZE);
  // Closed ring one pixel outside each window, corners included.
  always_comb begin
    w_border = (v_q >= C_BY0) && (v_q <= C_BY1) && !w_rom && !w_ram &&
               (((h_q >= C_BR0) && (h_q <= C_BR1)) ||
                ((h_q >= C_BM0) && (h_q <= C_BM1)));
  end
`else
  assign w_border = 1'b0;
`endif

  always_comb begin
    w_cls = CLS_NONE;
    if (w_rom)         w_cls = CLS_ROM;
    else if (w_ram)    w_cls = CLS_RAM;
    else if (w_border) w_cls = CLS_WHITE;
  end

  always_comb begin
    phase_d  = ~phase_q;
    h_d      = h_q;
    v_d      = v_q;
    addr_d   = addr_q;
    cls1_d   = cls1_q;
    blank1_d = blank1_q;
    hs1_d    = hs1_q;
    vs1_d    = vs1_q;
    pix_d    = pix_q;
    blank_d  = blank_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    frame_d  = 1'b0;
    if (phase_q) begin
      if (h_q == C_H_LAST) begin
        h_d = '0;
        v_d = (v_q == C_V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
      frame_d  = (h_q == C_H_LAST) && (v_q == C_V_LAST);
      addr_d   = w_addr;
      cls1_d   = w_cls;
      blank1_d = w_vis;
      hs1_d    = !((h_q >= C_HS_BEG) && (h_q < C_HS_END));
      vs1_d    = !((v_q >= C_VS_BEG) && (v_q < C_VS_END));
      // Second stage: memory data for the stage-1 address has landed by now.
      blank_d  = blank1_q;
      hs_d     = hs1_q;
      vs_d     = vs1_q;
      case (cls1_q)
        CLS_ROM:   pix_d = GPUDataRom;
        CLS_RAM:   pix_d = GPUData;
        CLS_WHITE: pix_d = 8'hFF;
        default:   pix_d = 8'h00;
      endcase
      if (!blank1_q) pix_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= 1'b0;
      h_q      <= '0;
      v_q      <= '0;
      addr_q   <= '0;
      cls1_q   <= CLS_NONE;
      blank1_q <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      pix_q    <= '0;
      blank_q  <= 1'b0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      h_q      <= h_d;
      v_q      <= v_d;
      addr_q   <= addr_d;
      cls1_q   <= cls1_d;
      blank1_q <= blank1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      pix_q    <= pix_d;
      blank_q  <= blank_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      frame_q  <= frame_d;
    end
  end

  assign GPUAddress = addr_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign blank_n    = blank_q;
  assign r          = pix_q;
  assign g          = pix_q;
  assign b          = pix_q;
  assign frameStart = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_gpu_scanout.sv
`default_nettype none
// tb_gpu_scanout : gpu_scanout on a reduced raster, checked against a
// position-based reference model with random image data and random resets.
module tb_gpu_scanout;

  localparam int H_ACTIVE = 40, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_ACTIVE = 24, V_FP = 1, V_SYNC = 2, V_BP = 3;
  localparam int IMG_SIZE = 8;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 48
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 30
  localparam int FRAME    = H_TOTAL * V_TOTAL;                 // pixel ticks
  // Window origins for this raster: margin 6, gap 12, centred vertically.
  localparam int ROM_X0   = 6;
  localparam int RAM_X0   = 26;
  localparam int WIN_Y0   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  GPUData, GPUDataRom;
  logic [15:0] GPUAddress;
  logic        hsync, vsync, blank_n, frameStart;
  logic [7:0]  r, g, b;

  logic [7:0]  rom_mem [0:63];
  logic [7:0]  ram_mem [0:63];

  int checks = 0, failures = 0;
  int k = 0, gclk = 0;
  int hs_fall = -1, vs_fall = -1, fs_last = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0;

  gpu_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .IMG_SIZE(IMG_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .GPUData(GPUData), .GPUDataRom(GPUDataRom),
    .GPUAddress(GPUAddress), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .r(r), .g(g), .b(b), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  // Synchronous image memories: data follows the address by one clock.
  always @(posedge clk) begin
    GPUData    <= ram_mem[GPUAddress[5:0]];
    GPUDataRom <= rom_mem[GPUAddress[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (clk %0d)", tag, got, exp, gclk);
    end
  endtask

  function automatic int px(int i); return i % H_TOTAL; endfunction
  function automatic int py(int i); return (i / H_TOTAL) % V_TOTAL; endfunction
  function automatic bit in_y(int y); return y >= WIN_Y0 && y < WIN_Y0 + IMG_SIZE; endfunction
  function automatic bit in_rom(int x, int y); return in_y(y) && x >= ROM_X0 && x < ROM_X0 + IMG_SIZE; endfunction
  function automatic bit in_ram(int x, int y); return in_y(y) && x >= RAM_X0 && x < RAM_X0 + IMG_SIZE; endfunction

  function automatic int exp_addr(int i);
    int x = px(i), y = py(i);
    if (in_rom(x, y)) return (y - WIN_Y0) * IMG_SIZE + (x - ROM_X0);
    if (in_ram(x, y)) return (y - WIN_Y0) * IMG_SIZE + (x - RAM_X0);
    return 0;
  endfunction

  function automatic logic [7:0] exp_pix(int i);
    int x = px(i), y = py(i);
    if (in_rom(x, y)) return rom_mem[(y - WIN_Y0) * IMG_SIZE + (x - ROM_X0)];
    if (in_ram(x, y)) return ram_mem[(y - WIN_Y0) * IMG_SIZE + (x - RAM_X0)];
`ifdef SCANOUT_BORDER_EN
    if (y >= WIN_Y0 - 1 && y <= WIN_Y0 + IMG_SIZE &&
        ((x >= ROM_X0 - 1 && x <= ROM_X0 + IMG_SIZE) ||
         (x >= RAM_X0 - 1 && x <= RAM_X0 + IMG_SIZE)))
      return 8'hFF;
`endif
    return 8'h00;
  endfunction

  task automatic step(input bit do_rst);
    int t, p, x, y;
    logic [7:0] ep;
    logic ehs, evs, ebl;
    string at, pt;
    rst = do_rst;
    @(posedge clk);
    #1;
    gclk++;
    if (do_rst) begin
      k = 0;
      check("rst_addr", GPUAddress, 32'd0);
      check("rst_rgb", {r, g, b}, 32'd0);
      check("rst_hsync", hsync, 32'd1);
      check("rst_vsync", vsync, 32'd1);
      check("rst_blank", blank_n, 32'd0);
      check("rst_frame", frameStart, 32'd0);
      hs_fall = -1; vs_fall = -1; fs_last = -1;
      prev_hs = 1'b1; prev_vs = 1'b1; prev_fs = 1'b0;
    end else begin
      k++;
      t = k / 2;
      // Address registered at tick t comes from the counter position t-1.
      p = (t >= 1) ? t - 1 : 0;
      x = px(p); y = py(p);
      at = "addr";
      if (t >= 1 && x == ROM_X0 && y == WIN_Y0) at = "addr_first";
      if (t >= 1 && x == ROM_X0 + IMG_SIZE - 1 && y == WIN_Y0 + IMG_SIZE - 1) at = "addr_last";
      if (t >= 1 && x == RAM_X0 && y == WIN_Y0 + 1) at = "addr_ram_row1";
      check(at, GPUAddress, (t >= 1) ? exp_addr(p) : 0);
      // Colour and syncs show the counter position from two ticks earlier.
      if (t >= 2) begin
        p = t - 2; x = px(p); y = py(p);
        ep  = exp_pix(p);
        ehs = !(x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC);
        evs = !(y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC);
        ebl = (x < H_ACTIVE) && (y < V_ACTIVE);
        pt = "pix";
        if (in_y(y) && x == ROM_X0 + IMG_SIZE) pt = "bound_rom_end";
        if (in_y(y) && x == RAM_X0 - 1)        pt = "bound_ram_start";
      end else begin
        ep = 8'h00; ehs = 1'b1; evs = 1'b1; ebl = 1'b0; pt = "pix_pre";
      end
      check(pt, {r, g, b}, {ep, ep, ep});
      check("hsync", hsync, ehs);
      check("vsync", vsync, evs);
      check("blank_n", blank_n, ebl);
      check("frameStart", frameStart, (k % 2 == 0) && (t > 0) && (t % FRAME == 0));

      if (prev_hs && !hsync) begin
        if (hs_fall >= 0) check("hs_period", gclk - hs_fall, 2 * H_TOTAL);
        hs_fall = gclk;
      end
      if (!prev_hs && hsync && hs_fall >= 0) check("hs_low", gclk - hs_fall, 2 * H_SYNC);
      if (prev_vs && !vsync) begin
        if (vs_fall >= 0) check("vs_period", gclk - vs_fall, 2 * FRAME);
        vs_fall = gclk;
      end
      if (!prev_vs && vsync && vs_fall >= 0) check("vs_low", gclk - vs_fall, 2 * V_SYNC * H_TOTAL);
      if (!prev_fs && frameStart) begin
        if (fs_last >= 0) check("fs_period", gclk - fs_last, 2 * FRAME);
        fs_last = gclk;
      end
      prev_hs = hsync; prev_vs = vsync; prev_fs = frameStart;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rom_mem[i] = 8'h3C;
      ram_mem[i] = 8'hA5;
    end
    repeat (4) step(1'b1);
    repeat (4 * FRAME + 400) step(1'b0);
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(300, 3000)) step(1'b0);
      step(1'b1);
      for (int i = 0; i < 64; i++) begin
        rom_mem[i] = 8'($urandom);
        ram_mem[i] = 8'($urandom);
      end
      step(1'b1);
      step(1'b1);
      repeat ($urandom_range(2 * FRAME, 2 * FRAME + 1500)) step(1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpu_scanout.md
GPU_SCANOUT -- requirements
Module: gpu_scanout

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP/H_SYNC/H_BP, 16/96/48: horizontal porches and sync, in pixels (total 800).
REQ-003 SHALL have parameter V_ACTIVE, 480: visible lines; V_FP/V_SYNC/V_BP, 10/2/33 (total 525).
REQ-004 SHALL have parameter IMG_SIZE, 256: square image edge; ROM window x 32..287, RAM window x 352..607, both y 112..367.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have ports: clk  in  1  system clock (50 MHz); rst  in  1  sync reset, active-high.
REQ-007 SHALL have ports: GPUData  in  8  RAM (decrypted) pixel; GPUDataRom  in  8  ROM (encrypted) pixel, both valid 1 clk after GPUAddress changes.
REQ-008 SHALL have ports: GPUAddress  out  16  pixel address = localY*256 + localX.
REQ-009 SHALL have ports: hsync, vsync  out  1  active-low syncs; blank_n  out  1  high in visible area.
REQ-010 SHALL have ports: r, g, b  out  8 each  colour; frameStart  out  1  one-clk pulse per frame.

Function
REQ-011 SHALL generate pixel tick pe on every 2nd clk (phase toggle); all state below advances only on pe cycles.
REQ-012 SHALL count hCount 0..799, wrapping 799->0 and incrementing vCount; vCount 0..524, wrapping 524->0.
REQ-013 SHALL drive hsync low for hCount 656..751 and vsync low for vCount 490..491 (before delay).
REQ-014 SHALL classify each (hCount,vCount) as ROM window, RAM window, or outside; outside includes all blanking.
REQ-015 SHALL register GPUAddress on pe: {vCount-112}[7:0]*256 + (hCount-32 or hCount-352)[7:0] in windows; 0 outside.
REQ-016 SHALL output pixel as grayscale r=g=b = GPUDataRom (ROM window) or GPUData (RAM window); 0 outside or when blank_n low.
REQ-017 SHALL delay window class, blank_n, hsync, vsync by exactly 2 pe ticks so colour and syncs for a counter position appear together, 2 ticks after that position.
REQ-018 SHALL change r/g/b/hsync/vsync/blank_n only on pe cycles (registered outputs).
REQ-019 SHALL pulse frameStart high for exactly one clk on the pe cycle where counters wrap (799,524)->(0,0).
REQ-020 SHALL treat window boundaries inclusive: x=287 is ROM pixel 255, x=288 black; x=351 black, x=352 RAM pixel 0.

Reset
REQ-021 SHALL on rst set hCount=vCount=0, pe phase=0, GPUAddress=0, r=g=b=0, hsync=vsync=1, blank_n=0, frameStart=0, delay pipeline cleared to inactive.
REQ-022 SHALL honour rst mid-frame on the next clk edge, abandoning the line; first pe after release is the 2nd clk.

Configuration
REQ-023 SHALL, with SCANOUT_BORDER_EN defined, draw white (r=g=b=255) 1-pixel frames on rows y=111, y=368 and columns x=31, 288, 351, 608 spanning each window's extent.
REQ-024 SHALL, without SCANOUT_BORDER_EN, output black at those positions; all other behaviour identical.

Verification
REQ-025 SHALL check reset: assert rst 3 clk mid-line -> all outputs at REQ-021 values; first pe on 2nd clk after release.
REQ-026 SHALL check timing: free-run 2 frames -> hsync period 1600 clk, low 192 clk; vsync period 840000 clk, low 3200 clk; frameStart every 840000 clk.
REQ-027 SHALL check addressing: counter at (x=32,y=112) -> GPUAddress 0x0000; (287,367) -> 0xFFFF; (352,113) -> 0x0100.
REQ-028 SHALL check data path: model returns GPUData=0xA5, GPUDataRom=0x3C -> RAM window r=g=b=0xA5, ROM window 0x3C, 2 pe after address, syncs aligned.
REQ-029 SHALL check boundaries: pixels x=288 and x=351 on y=200 -> 0x00 (0xFF with SCANOUT_BORDER_EN only at x=288, 351).
